// File: rtl/multi_ch_timeout_mon_pkg.sv
// Shared defaults and types for the multi-channel timeout monitor.
// Channel count, counter widths and the late-flag mode live here so the top, interface and bench agree.
package health_mon_pkg;

   localparam int unsigned N_CH_DEFAULT        = 4;
   localparam int unsigned CNT_W_DEFAULT       = 14;
   localparam int unsigned MISS_W_DEFAULT      = 4;
   localparam int unsigned WARN_MARGIN_DEFAULT = 1000;

   // 10 s at a 1 kHz tick
   localparam logic [13:0] TEN_SEC_TICKS = 14'd10000;

   typedef enum logic {
      LATE_PULSE,
      LATE_STICKY
   } late_mode_e;

endpackage

// File: rtl/multi_ch_timeout_mon_if.sv
// Control and status bundle of the timeout monitor.
// The master drives the strobes and the limit, and the slave (the monitor) returns the flags.
interface multi_ch_timeout_mon_if
   import health_mon_pkg::*;
#(
   parameter int unsigned N_CH   = N_CH_DEFAULT,
   parameter int unsigned CNT_W  = CNT_W_DEFAULT,
   parameter int unsigned MISS_W = MISS_W_DEFAULT
);

   logic                     tick;
   logic [N_CH-1:0]          enb;
   logic [N_CH-1:0]          kick;
   logic [N_CH-1:0]          clr_late;
   logic [CNT_W-1:0]         limit;
   logic [N_CH-1:0]          late;
   logic [N_CH-1:0]          warn;
   logic                     any_late;
   logic [N_CH*MISS_W-1:0]   miss_cnt;

   modport master (
      output tick, enb, kick, clr_late, limit,
      input  late, warn, any_late, miss_cnt
   );

   modport slave (
      input  tick, enb, kick, clr_late, limit,
      output late, warn, any_late, miss_cnt
   );

endinterface

// File: rtl/multi_ch_timeout_mon_ch.sv
// One timeout channel: tick counter, late flag, early warning and saturating miss counter.
// Edge priority is !enb > kick > expiry > count > clr_late.
module timeout_ch
   import health_mon_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned MISS_W      = MISS_W_DEFAULT,
   parameter int unsigned WARN_MARGIN = WARN_MARGIN_DEFAULT,
   parameter int unsigned STICKY      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              enb,
   input  logic              kick,
   input  logic              clr_late,
   input  logic [CNT_W-1:0]  limit,
   output logic              late,
   output logic              warn,
   output logic [MISS_W-1:0] miss_cnt
);

   localparam late_mode_e       Mode    = (STICKY != 0) ? LATE_STICKY : LATE_PULSE;
   localparam logic [MISS_W-1:0] MissMax = '1;
   localparam logic [CNT_W:0]   Margin  = (CNT_W+1)'(WARN_MARGIN);

   logic [CNT_W-1:0]  count_q, count_d;
   logic              late_q, late_d;
   logic              warn_q, warn_d;
   logic [MISS_W-1:0] miss_q, miss_d;

   // One extra bit keeps limit-1 and limit-margin from wrapping
   logic [CNT_W:0] limit_ext, limit_m1, warn_thr;
   logic           active, expire;

   always_comb begin
      limit_ext = {1'b0, limit};
      limit_m1  = limit_ext - (CNT_W+1)'(1);
      warn_thr  = (limit_ext > Margin) ? (limit_ext - Margin) : '0;
      active    = tick && (limit != '0) && !((Mode == LATE_STICKY) && late_q);
      // >= so that lowering the limit below the running count expires on the next tick
      expire    = active && ({1'b0, count_q} >= limit_m1);

      count_d = count_q;
      late_d  = ((Mode == LATE_STICKY) && !clr_late) ? late_q : 1'b0;
      miss_d  = miss_q;

      if (!enb) begin
         count_d = '0;
         late_d  = 1'b0;
         miss_d  = '0;
      end else if (kick) begin
         count_d = '0;
         late_d  = 1'b0;
      end else if (expire) begin
         count_d = '0;
         late_d  = 1'b1;
         if (miss_q != MissMax) begin
            miss_d = miss_q + MISS_W'(1);
         end
      end else if (active) begin
         count_d = count_q + CNT_W'(1);
      end

      warn_d = enb && !kick && (limit != '0) && !late_d && ({1'b0, count_d} >= warn_thr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         late_q  <= 1'b0;
         warn_q  <= 1'b0;
         miss_q  <= '0;
      end else begin
         count_q <= count_d;
         late_q  <= late_d;
         warn_q  <= warn_d;
         miss_q  <= miss_d;
      end
   end

   assign late     = late_q;
   assign warn     = warn_q;
   assign miss_cnt = miss_q;

endmodule

// File: rtl/multi_ch_timeout_mon.sv
// N-channel programmable timeout monitor: independent channels sharing tick and limit,
// plus a registered OR of all late flags.
module multi_ch_timeout_mon
   import health_mon_pkg::*;
#(
   parameter int unsigned N_CH        = N_CH_DEFAULT,
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned MISS_W      = MISS_W_DEFAULT,
   parameter int unsigned WARN_MARGIN = WARN_MARGIN_DEFAULT,
   parameter int unsigned STICKY      = 1
) (
   input logic                   clk,
   input logic                   rst,
   multi_ch_timeout_mon_if.slave bus
);

   logic [N_CH-1:0]        late_vec;
   logic [N_CH-1:0]        warn_vec;
   logic [N_CH*MISS_W-1:0] miss_vec;
   logic                   any_late_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timeout_ch #(
         .CNT_W       (CNT_W),
         .MISS_W      (MISS_W),
         .WARN_MARGIN (WARN_MARGIN),
         .STICKY      (STICKY)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick     (bus.tick),
         .enb      (bus.enb[i]),
         .kick     (bus.kick[i]),
         .clr_late (bus.clr_late[i]),
         .limit    (bus.limit),
         .late     (late_vec[i]),
         .warn     (warn_vec[i]),
         .miss_cnt (miss_vec[i*MISS_W +: MISS_W])
      );
   end

   // Built from the late registers, so any_late trails late by one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         any_late_q <= 1'b0;
      end else begin
         any_late_q <= |late_vec;
      end
   end

   assign bus.late     = late_vec;
   assign bus.warn     = warn_vec;
   assign bus.miss_cnt = miss_vec;
   assign bus.any_late = any_late_q;

endmodule

// File: tb/tb_multi_ch_timeout_mon.sv
// Bench for multi_ch_timeout_mon: directed scenarios plus randomized traffic checked against
// a per-channel behavioural model, on a sticky instance and a pulse-mode instance.
module tb_multi_ch_timeout_mon;

   localparam int unsigned NCH      = 4;
   localparam int unsigned A_CNT_W  = 14;
   localparam int unsigned A_MISS_W = 4;
   localparam int unsigned A_MARGIN = 1000;
   localparam int unsigned B_CNT_W  = 8;
   localparam int unsigned B_MISS_W = 2;
   localparam int unsigned B_MARGIN = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   multi_ch_timeout_mon_if #(.N_CH(NCH), .CNT_W(A_CNT_W), .MISS_W(A_MISS_W)) bus_a ();
   multi_ch_timeout_mon_if #(.N_CH(NCH), .CNT_W(B_CNT_W), .MISS_W(B_MISS_W)) bus_b ();

   multi_ch_timeout_mon #(
      .N_CH(NCH), .CNT_W(A_CNT_W), .MISS_W(A_MISS_W), .WARN_MARGIN(A_MARGIN), .STICKY(1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   multi_ch_timeout_mon #(
      .N_CH(NCH), .CNT_W(B_CNT_W), .MISS_W(B_MISS_W), .WARN_MARGIN(B_MARGIN), .STICKY(0)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   always #5 clk = ~clk;

   // Behavioural reference: index 0 = sticky instance, 1 = pulse instance
   int m_cnt  [2][NCH];
   bit m_late [2][NCH];
   bit m_warn [2][NCH];
   int m_miss [2][NCH];
   bit m_any  [2];

   task automatic model_step(input int d, input bit tk, input logic [NCH-1:0] en,
                             input logic [NCH-1:0] kk, input logic [NCH-1:0] cl, input int lim,
                             input bit sticky, input int margin, input int max_miss);
      bit any;
      bit counting;
      int thr;
      any = 1'b0;
      for (int c = 0; c < NCH; c++) any |= m_late[d][c];
      m_any[d] = any;
      thr = (lim > margin) ? lim - margin : 0;
      for (int c = 0; c < NCH; c++) begin
         if (!en[c]) begin
            m_cnt[d][c] = 0; m_late[d][c] = 0; m_warn[d][c] = 0; m_miss[d][c] = 0;
         end else if (kk[c]) begin
            m_cnt[d][c] = 0; m_late[d][c] = 0; m_warn[d][c] = 0;
         end else begin
            counting = tk && lim != 0 && !(sticky && m_late[d][c]);
            if (counting && m_cnt[d][c] + 1 >= lim) begin
               m_cnt[d][c]  = 0;
               m_late[d][c] = 1;
               if (m_miss[d][c] < max_miss) m_miss[d][c]++;
            end else begin
               if (counting) m_cnt[d][c]++;
               if (!sticky || cl[c]) m_late[d][c] = 0;
            end
            m_warn[d][c] = lim != 0 && !m_late[d][c] && m_cnt[d][c] >= thr;
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_any[d] = 0;
            for (int c = 0; c < NCH; c++) begin
               m_cnt[d][c] = 0; m_late[d][c] = 0; m_warn[d][c] = 0; m_miss[d][c] = 0;
            end
         end
      end else begin
         model_step(0, bus_a.tick, bus_a.enb, bus_a.kick, bus_a.clr_late, int'(bus_a.limit),
                    1'b1, A_MARGIN, 15);
         model_step(1, bus_b.tick, bus_b.enb, bus_b.kick, bus_b.clr_late, int'(bus_b.limit),
                    1'b0, B_MARGIN, 3);
      end
   end

   task automatic clear_inputs();
      bus_a.tick = 0; bus_a.enb = '0; bus_a.kick = '0; bus_a.clr_late = '0; bus_a.limit = '0;
      bus_b.tick = 0; bus_b.enb = '0; bus_b.kick = '0; bus_b.clr_late = '0; bus_b.limit = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (bus_a.late !== '0 || bus_a.warn !== '0 || bus_a.any_late !== 1'b0 ||
          bus_a.miss_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_state late=%b warn=%b any=%b miss=%h, required all 0",
                  bus_a.late, bus_a.warn, bus_a.any_late, bus_a.miss_cnt);
      end
      bus_a.limit = 14'd1000;
      bus_a.enb   = 4'b0001;
      bus_a.tick  = 1;
      repeat (500) @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.warn[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_precheck_warn got=%b required=1", bus_a.warn[0]);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (bus_a.late !== '0 || bus_a.warn !== '0 || bus_a.any_late !== 1'b0 ||
          bus_a.miss_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_async late=%b warn=%b any=%b miss=%h, required all 0",
                  bus_a.late, bus_a.warn, bus_a.any_late, bus_a.miss_cnt);
      end
   endtask

   task automatic test_basic_expiry();
      do_reset();
      bus_a.limit = 14'd10;
      bus_a.enb   = 4'b0001;
      bus_a.tick  = 1;
      repeat (9) @(negedge clk);
      n_tests++;
      if (bus_a.late[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL expiry_early late0 got=%b required=0", bus_a.late[0]);
      end
      @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.late[0] !== 1'b1 || bus_a.miss_cnt[3:0] !== 4'd1 || bus_a.any_late !== 1'b0) begin
         n_fail++;
         $display("FAIL expiry_edge late0=%b miss0=%0d any=%b, required 1/1/0",
                  bus_a.late[0], bus_a.miss_cnt[3:0], bus_a.any_late);
      end
      @(negedge clk);
      n_tests++;
      if (bus_a.any_late !== 1'b1 || bus_a.late[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL expiry_any_late any=%b late0=%b, required 1/1",
                  bus_a.any_late, bus_a.late[0]);
      end
   endtask

   task automatic test_warn();
      do_reset();
      bus_a.limit = 14'd2000;
      bus_a.enb   = 4'b0010;
      bus_a.tick  = 1;
      repeat (999) @(negedge clk);
      n_tests++;
      if (bus_a.warn[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL warn_before got=%b required=0", bus_a.warn[1]);
      end
      @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.warn[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL warn_rise got=%b required=1", bus_a.warn[1]);
      end
      bus_a.kick = 4'b0010;
      @(negedge clk);
      bus_a.kick = '0;
      n_tests++;
      if (bus_a.warn[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL warn_kick got=%b required=0", bus_a.warn[1]);
      end
   endtask

   task automatic test_kick_vs_expiry();
      do_reset();
      bus_a.limit = 14'd10;
      bus_a.enb   = 4'b0001;
      bus_a.tick  = 1;
      repeat (9) @(negedge clk);
      bus_a.kick = 4'b0001;
      @(negedge clk);
      bus_a.kick = '0;
      n_tests++;
      if (bus_a.late[0] !== 1'b0 || bus_a.miss_cnt[3:0] !== 4'd0) begin
         n_fail++;
         $display("FAIL kick_wins late0=%b miss0=%0d, required 0/0",
                  bus_a.late[0], bus_a.miss_cnt[3:0]);
      end
      repeat (9) @(negedge clk);
      n_tests++;
      if (bus_a.late[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL kick_restart_early late0=%b required=0", bus_a.late[0]);
      end
      @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.late[0] !== 1'b1 || bus_a.miss_cnt[3:0] !== 4'd1) begin
         n_fail++;
         $display("FAIL kick_restart_expiry late0=%b miss0=%0d, required 1/1",
                  bus_a.late[0], bus_a.miss_cnt[3:0]);
      end
   endtask

   task automatic test_sticky_clear();
      do_reset();
      bus_a.limit = 14'd4;
      bus_a.enb   = 4'b0100;
      bus_a.tick  = 1;
      repeat (9) @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.late[2] !== 1'b1 || bus_a.miss_cnt[11:8] !== 4'd1) begin
         n_fail++;
         $display("FAIL sticky_hold late2=%b miss2=%0d, required 1/1",
                  bus_a.late[2], bus_a.miss_cnt[11:8]);
      end
      bus_a.clr_late = 4'b0100;
      @(negedge clk);
      bus_a.clr_late = '0;
      n_tests++;
      if (bus_a.late[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_clr late2=%b required=0", bus_a.late[2]);
      end
      bus_a.tick = 1;
      repeat (3) @(negedge clk);
      bus_a.clr_late = 4'b0100;
      @(negedge clk);
      bus_a.clr_late = '0;
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.late[2] !== 1'b1 || bus_a.miss_cnt[11:8] !== 4'd2) begin
         n_fail++;
         $display("FAIL clr_vs_expiry late2=%b miss2=%0d, required 1/2",
                  bus_a.late[2], bus_a.miss_cnt[11:8]);
      end
   endtask

   task automatic test_pulse_mode();
      int pulses;
      do_reset();
      bus_b.limit = 8'd5;
      bus_b.enb   = 4'b0001;
      bus_b.tick  = 1;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus_b.late[0] === 1'b1) pulses++;
      end
      bus_b.tick = 0;
      n_tests++;
      if (pulses != 3) begin
         n_fail++;
         $display("FAIL pulse_count got=%0d required=3", pulses);
      end
      @(negedge clk);
      n_tests++;
      if (bus_b.late[0] !== 1'b0 || bus_b.miss_cnt[1:0] !== 2'd3) begin
         n_fail++;
         $display("FAIL pulse_width late0=%b miss0=%0d, required 0/3",
                  bus_b.late[0], bus_b.miss_cnt[1:0]);
      end
      bus_b.tick = 1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_b.late[0] === 1'b1) pulses++;
      end
      bus_b.tick = 0;
      n_tests++;
      if (pulses != 2 || bus_b.miss_cnt[1:0] !== 2'd3) begin
         n_fail++;
         $display("FAIL miss_saturate pulses=%0d miss0=%0d, required 2/3",
                  pulses, bus_b.miss_cnt[1:0]);
      end
   endtask

   task automatic test_limit_change();
      do_reset();
      bus_a.limit = 14'd100;
      bus_a.enb   = 4'b1000;
      bus_a.tick  = 1;
      repeat (50) @(negedge clk);
      bus_a.limit = 14'd10;
      @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.late[3] !== 1'b1 || bus_a.miss_cnt[15:12] !== 4'd1) begin
         n_fail++;
         $display("FAIL limit_lowered late3=%b miss3=%0d, required 1/1",
                  bus_a.late[3], bus_a.miss_cnt[15:12]);
      end
      bus_a.limit = '0;
      bus_a.kick  = 4'b1000;
      @(negedge clk);
      bus_a.kick = '0;
      bus_a.tick = 1;
      repeat (20) @(negedge clk);
      bus_a.tick = 0;
      n_tests++;
      if (bus_a.late[3] !== 1'b0 || bus_a.warn[3] !== 1'b0 || bus_a.miss_cnt[15:12] !== 4'd1) begin
         n_fail++;
         $display("FAIL limit_zero late3=%b warn3=%b miss3=%0d, required 0/0/1",
                  bus_a.late[3], bus_a.warn[3], bus_a.miss_cnt[15:12]);
      end
      bus_a.limit = 14'd10;
      @(negedge clk);
      n_tests++;
      if (bus_a.warn[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL limit_restored_warn warn3=%b required=1", bus_a.warn[3]);
      end
   endtask

   task automatic test_random();
      logic [NCH-1:0] e_late, e_warn;
      logic [NCH*A_MISS_W-1:0] e_miss_a;
      logic [NCH*B_MISS_W-1:0] e_miss_b;
      logic [13:0] lim;
      do_reset();
      for (int cyc = 0; cyc < 3000 && n_fail < 20; cyc++) begin
         if (cyc % 64 == 0) begin
            lim = ($urandom % 4 == 0) ? 14'(1000 + $urandom_range(0, 20))
                                      : 14'($urandom_range(0, 24));
            bus_a.limit = lim;
            bus_b.limit = 8'($urandom_range(0, 24));
         end
         bus_a.tick = ($urandom % 3) != 0;
         bus_b.tick = bus_a.tick;
         for (int c = 0; c < NCH; c++) begin
            bus_a.enb[c]      = ($urandom % 16) != 0;
            bus_a.kick[c]     = ($urandom % 20) == 0;
            bus_a.clr_late[c] = ($urandom % 10) == 0;
         end
         bus_b.enb      = bus_a.enb;
         bus_b.kick     = bus_a.kick;
         bus_b.clr_late = ~bus_a.clr_late & 4'($urandom);
         @(negedge clk);
         for (int c = 0; c < NCH; c++) begin
            e_late[c] = m_late[0][c];
            e_warn[c] = m_warn[0][c];
            e_miss_a[c*A_MISS_W +: A_MISS_W] = A_MISS_W'(m_miss[0][c]);
         end
         n_tests++;
         if (bus_a.late !== e_late || bus_a.warn !== e_warn || bus_a.miss_cnt !== e_miss_a ||
             bus_a.any_late !== m_any[0]) begin
            n_fail++;
            $display("FAIL rand_sticky cyc=%0d got late=%b warn=%b miss=%h any=%b required %b/%b/%h/%b",
                     cyc, bus_a.late, bus_a.warn, bus_a.miss_cnt, bus_a.any_late,
                     e_late, e_warn, e_miss_a, m_any[0]);
         end
         for (int c = 0; c < NCH; c++) begin
            e_late[c] = m_late[1][c];
            e_warn[c] = m_warn[1][c];
            e_miss_b[c*B_MISS_W +: B_MISS_W] = B_MISS_W'(m_miss[1][c]);
         end
         n_tests++;
         if (bus_b.late !== e_late || bus_b.warn !== e_warn || bus_b.miss_cnt !== e_miss_b ||
             bus_b.any_late !== m_any[1]) begin
            n_fail++;
            $display("FAIL rand_pulse cyc=%0d got late=%b warn=%b miss=%h any=%b required %b/%b/%h/%b",
                     cyc, bus_b.late, bus_b.warn, bus_b.miss_cnt, bus_b.any_late,
                     e_late, e_warn, e_miss_b, m_any[1]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_basic_expiry();
      test_warn();
      test_kick_vs_expiry();
      test_sticky_clear();
      test_pulse_mode();
      test_limit_change();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
